sprite_renderer: RTL
====================

Name: sprite_renderer

Overview:
- Per-frame rasteriser that sits directly downstream of the player sprite block.
- On each game frame it scans the 320x240 canvas and drives PixelX/PixelY into the player block.
- It consumes is_obj/Obj_address, fetches the sprite colour index from the sprite ROM and resolves transparency against a background colour.
- It writes every pixel into the frame buffer through a valid/ready write port that supports backpressure.

Parameters:
- H_RES, 320, canvas width in pixels.
- V_RES, 240, canvas height in pixels.
- COLOR_W, 4, colour-index width (palette entries).
- ROM_LATENCY, 2, sprite ROM read latency in clock cycles while rom_ce is high.
- TRANSPARENT, 4'd0, colour index treated as transparent.

Ports:
- Clk  in  1  50 MHz system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  ~60 Hz frame tick (asynchronous level); a rising edge starts a frame.
- is_obj  in  1  player block: current PixelX/PixelY lies inside the sprite.
- Obj_address  in  16  player block: sprite ROM address for the current pixel.
- PixelX  out  9  scan column 0..H_RES-1, fed to the player block.
- PixelY  out  9  scan row 0..V_RES-1, fed to the player block.
- rom_addr  out  16  sprite ROM address.
- rom_ce  out  1  sprite ROM clock enable; low freezes the ROM pipeline.
- rom_data  in  COLOR_W  sprite ROM colour index, ROM_LATENCY cycles after the address while rom_ce is high.
- bg_color  in  COLOR_W  background colour index, static during a frame.
- fb_addr  out  17  frame-buffer word address, computed as y*H_RES+x.
- fb_data  out  COLOR_W  resolved colour index.
- fb_we  out  1  write valid.
- fb_ready  in  1  frame buffer accepts the write this cycle.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse after the last write of a frame is accepted.
- frame_overrun  out  1  one-cycle pulse when a frame tick arrives while busy.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; PixelX=PixelY=0; rom_addr=0; rom_ce=0; fb_we=0; fb_addr=0; fb_data=0; busy=0; frame_done=0; frame_overrun=0; pipeline valid bits cleared.
  - Asserting Reset mid-frame aborts the frame: no further writes, and no frame_done.
- frame_clk handling: two-flop synchroniser plus edge detector; start is a one-cycle pulse.
- FSM states IDLE, SCAN, DRAIN:
  - IDLE -> SCAN on start. PixelX/PixelY are set to 0,0 and busy goes to 1.
  - SCAN: each non-stalled cycle, the current (x,y,is_obj,Obj_address) enters the pipeline. The counter advances x; at x=H_RES-1 it wraps x to 0 and increments y.
  - SCAN -> DRAIN when (H_RES-1,V_RES-1) is issued. The counters hold at their last value.
  - DRAIN: no new issue. Go to IDLE when the pipeline is empty and the final write has been accepted; in that cycle frame_done=1 and busy drops to 0 in the same cycle.
  - start while not IDLE: ignored, frame_overrun=1 for one cycle.
- Pipeline, stage 0 to write stage:
  - Stage 0 registers rom_addr = Obj_address when is_obj=1, else 0.
  - A shift register of depth ROM_LATENCY carries valid, x, y and is_obj in step with the ROM.
  - Output stage: colour = rom_data when is_obj=1 and rom_data!=TRANSPARENT, else bg_color.
  - The output stage registers fb_data and fb_addr = y*H_RES+x (max 76799, 17 bits) and asserts fb_we.
- Fill latency: the first fb_we appears ROM_LATENCY+2 cycles after start.
- Throughput: 1 pixel/clock with fb_ready held high; one frame is exactly H_RES*V_RES writes.
- Backpressure:
  - stall = fb_we & ~fb_ready.
  - During stall, all pipeline registers, the scan counters and rom_ce (driven to 0) hold. fb_we, fb_addr and fb_data stay stable until accepted.
  - A write is accepted on a cycle where fb_we=1 and fb_ready=1.
  - rom_ce = ~stall whenever busy, and 0 in IDLE.
- Simultaneous events: start and the DRAIN->IDLE completion in the same cycle give frame_done=1 and start is treated as overrun (ignored). The next frame needs a new edge.
- Each pixel address is written exactly once per frame, in raster order, with no gaps or duplicates.

Decomposition:
- Shared package renderer_pkg holds:
  - H_RES/V_RES constants;
  - COLOR_W;
  - typedef color_t;
  - the enum typedef for the IDLE/SCAN/DRAIN states;
  - a typedef struct pix_tag_t {valid, x, y, is_obj} for the pipeline tag.
- One sub-module: frame_tick_sync, the two-flop synchroniser plus rising-edge pulse for frame_clk.
- The scan counter, pipeline and FSM stay in sprite_renderer.

Test Plan:
- Reset then a single frame_clk edge, player model with is_obj=0 always, bg_color=4'h5, fb_ready=1 -> 76800 writes, addr 0..76799 in order, all data 5. frame_done is exactly one pulse, at ROM_LATENCY+2+76800-1 cycles after start.
- Player model is_obj=1 over the box x 140..179, y 88..151; ROM model returns 3 except returns TRANSPARENT at Obj_address=0 -> box pixels are 3 and the transparent pixel is bg_color. Check addr 88*320+140=28300 and its neighbours.
- fb_ready pseudo-random at 50% -> same address/data sequence as with fb_ready=1. fb_we/addr/data are stable on every stalled cycle, and rom_ce is low exactly when stalled.
- Second frame_clk edge mid-frame -> frame_overrun pulses once, the write sequence is unaffected and only one frame_done is issued.
- Reset asserted at write 40000 -> fb_we=0 immediately (asynchronous) and busy=0. A new frame_clk edge restarts from addr 0 with no frame_done from the aborted frame.
- x/y wrap: observe PixelX 319->0 with PixelY incrementing at each row end. After the issue at (319,239) there is no further PixelX/PixelY change until the next frame.

Source files
------------

// File: rtl/sprite_renderer_pkg.sv
// Shared constants, types and helpers for the sprite renderer.
package renderer_pkg;

    localparam int H_RES       = 320;
    localparam int V_RES       = 240;
    localparam int COLOR_W     = 4;
    localparam int ROM_LATENCY = 2;

    typedef logic [COLOR_W-1:0] color_t;

    localparam color_t TRANSPARENT = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } render_state_e;

    // Tag that travels beside the ROM read so the output stage knows which pixel it has.
    typedef struct packed {
        logic       valid;
        logic [8:0] x;
        logic [8:0] y;
        logic       is_obj;
    } pix_tag_t;

    // Linear frame-buffer word address for a canvas of the given width.
    function automatic logic [16:0] pix_addr(input logic [8:0] x, input logic [8:0] y,
                                             input int width);
        return 17'(y) * 17'(width) + 17'(x);
    endfunction

endpackage

// File: rtl/sprite_renderer_if.sv
// Frame-buffer write port: valid (fb_we) / ready (fb_ready) with address and colour.
interface sprite_renderer_if;
    import renderer_pkg::*;

    logic [16:0] fb_addr;
    color_t      fb_data;
    logic        fb_we;
    logic        fb_ready;

    modport master (output fb_addr, output fb_data, output fb_we, input fb_ready);
    modport slave  (input fb_addr, input fb_data, input fb_we, output fb_ready);
endinterface

// File: rtl/sprite_renderer_frame_tick_sync.sv
// Brings the asynchronous frame tick into the clock domain and emits a
// one-cycle pulse on its rising edge. The edge flop resets low, so a tick
// already high when reset is released counts as an edge.
module frame_tick_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_pulse
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Two-flop synchroniser followed by an edge-history flop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_pulse = r_sync & ~r_prev;
endmodule

// File: rtl/sprite_renderer.sv
// Sprite renderer: scans the canvas once per frame tick, looks up the sprite
// colour, resolves transparency against the background and streams every
// pixel to the frame buffer with backpressure.
//
// state | meaning
// IDLE  | waiting for a frame tick; scan counters hold the last pixel issued
// SCAN  | issuing one pixel per unstalled cycle in raster order
// DRAIN | all pixels issued; waiting for the pipeline to empty and the last write
module sprite_renderer
    import renderer_pkg::*;
#(
    parameter int P_H_RES = H_RES,
    parameter int P_V_RES = V_RES
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               is_obj,
    input  logic [15:0]        Obj_address,
    output logic [8:0]         PixelX,
    output logic [8:0]         PixelY,
    output logic [15:0]        rom_addr,
    output logic               rom_ce,
    input  color_t             rom_data,
    input  color_t             bg_color,
    sprite_renderer_if.master  fb,
    output logic               busy,
    output logic               frame_done,
    output logic               frame_overrun
);
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_SCAN  = ST_SCAN;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;
    localparam logic [8:0] X_LAST  = 9'(P_H_RES - 1);
    localparam logic [8:0] Y_LAST  = 9'(P_V_RES - 1);
    localparam int         LAST    = ROM_LATENCY - 1;

    logic [1:0]  r_state;
    logic [8:0]  r_x;
    logic [8:0]  r_y;
    logic [15:0] r_rom_addr;
    pix_tag_t    r_tag0;
    pix_tag_t    r_pipe [ROM_LATENCY];
    logic        r_fb_we;
    logic [16:0] r_fb_addr;
    color_t      r_fb_data;
    logic        r_overrun;

    logic        w_start;
    logic        w_stall;
    logic        w_issue;
    logic        w_last_pix;
    logic        w_pipe_empty;
    logic        w_done;
    color_t      w_color;

    frame_tick_sync u_tick_sync (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_async (frame_clk),
        .o_pulse (w_start)
    );

    assign w_stall    = r_fb_we & ~fb.fb_ready;
    assign w_issue    = (r_state == S_SCAN) & ~w_stall;
    assign w_last_pix = (r_x == X_LAST) && (r_y == Y_LAST);

    // Pipeline is empty when no tag ahead of the output stage is valid.
    always_comb begin
        w_pipe_empty = ~r_tag0.valid;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            if (r_pipe[i].valid) w_pipe_empty = 1'b0;
        end
    end

    // The frame completes in the cycle its final write is accepted.
    assign w_done  = (r_state == S_DRAIN) & w_pipe_empty & r_fb_we & fb.fb_ready;
    assign busy    = (r_state != S_IDLE) & ~w_done;
    assign rom_ce  = busy & ~w_stall;
    assign w_color = (r_pipe[LAST].is_obj && (rom_data != TRANSPARENT)) ? rom_data : bg_color;

    // Frame FSM and raster scan counters.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_start & (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_SCAN;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_issue) begin
                        if (w_last_pix) begin
                            r_state <= S_DRAIN;
                        end else if (r_x == X_LAST) begin
                            r_x <= '0;
                            r_y <= r_y + 9'd1;
                        end else begin
                            r_x <= r_x + 9'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_done) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Issue stage, tag shift register in step with the ROM, and output register; all freeze on stall.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rom_addr <= '0;
            r_tag0     <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) r_pipe[i] <= '0;
            r_fb_we    <= 1'b0;
            r_fb_addr  <= '0;
            r_fb_data  <= '0;
        end else if (!w_stall) begin
            r_rom_addr <= (w_issue && is_obj) ? Obj_address : 16'h0;
            r_tag0     <= '{valid: w_issue, x: r_x, y: r_y, is_obj: is_obj};
            r_pipe[0]  <= r_tag0;
            for (int i = 1; i < ROM_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
            r_fb_we    <= r_pipe[LAST].valid;
            if (r_pipe[LAST].valid) begin
                r_fb_addr <= pix_addr(r_pipe[LAST].x, r_pipe[LAST].y, P_H_RES);
                r_fb_data <= w_color;
            end
        end
    end

    assign PixelX        = r_x;
    assign PixelY        = r_y;
    assign rom_addr      = r_rom_addr;
    assign fb.fb_we      = r_fb_we;
    assign fb.fb_addr    = r_fb_addr;
    assign fb.fb_data    = r_fb_data;
    assign frame_done    = w_done;
    assign frame_overrun = r_overrun;
endmodule
